// File: rtl/rx_bit_timer.sv
// Per-bit timing generator for one UART receive frame: mid-bit sample strobe,
// end-of-bit shift strobe, bit index / field type and a frame-done pulse.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for enable_timer; checks and latches the configuration
// DELAY | START_DELAY cycles to line up with the input synchroniser
// RUN   | counting bit periods, emitting strobes
// HOLD  | frame finished or start refused; waits for enable_timer to drop
module rx_bit_timer #(
    parameter int PERIOD_W    = 14,
    parameter int SIZE_W      = 4,
    parameter int START_DELAY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_timer,
    input  logic [PERIOD_W-1:0] bit_period,
    input  logic [SIZE_W-1:0]   data_size,
    input  logic                parity_en,
    input  logic                two_stop,
    output logic                sample_strobe,
    output logic                shift_strobe,
    output logic                packet_done,
    output logic [SIZE_W:0]     bit_index,
    output logic [1:0]          field,
    output logic                busy,
    output logic                cfg_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_RUN   = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam int DELAY_INIT = (START_DELAY > 0) ? START_DELAY - 1 : 0;

    localparam logic [1:0] FIELD_IDLE   = 2'd0;
    localparam logic [1:0] FIELD_DATA   = 2'd1;
    localparam logic [1:0] FIELD_PARITY = 2'd2;
    localparam logic [1:0] FIELD_STOP   = 2'd3;

    state_t state_q;
    state_t state_d;

    logic [PERIOD_W-1:0] period_q;
    logic [SIZE_W-1:0]   size_q;
    logic                parity_q;
    logic                two_stop_q;

    logic [2:0]          dly_cnt;
    logic [PERIOD_W-1:0] cnt;
    logic [SIZE_W:0]     bit_cnt;
    logic                cfg_err_q;

    logic                cfg_ok;
    logic [SIZE_W+1:0]   frame_len;
    logic [SIZE_W+1:0]   last_idx;
    logic [PERIOD_W-1:0] half_period;
    logic                at_sample;
    logic                at_shift;
    logic                last_bit;

    assign cfg_ok = (bit_period >= PERIOD_W'(2)) && (data_size != '0);

    // Widened by two bits so data + parity + two stop bits never wraps.
    assign frame_len = (SIZE_W+2)'(size_q) + (SIZE_W+2)'(parity_q)
                     + (two_stop_q ? (SIZE_W+2)'(2) : (SIZE_W+2)'(1));
    assign last_idx  = frame_len - (SIZE_W+2)'(1);

    assign half_period = period_q >> 1;
    assign at_sample   = (cnt == half_period);
    assign at_shift    = (cnt == period_q);
    assign last_bit    = ({1'b0, bit_cnt} == last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable_timer) begin
                    if (!cfg_ok) begin
                        state_d = S_HOLD;
                    end else if (START_DELAY == 0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DELAY;
                    end
                end
            end
            S_DELAY: begin
                if (!enable_timer) begin
                    state_d = S_IDLE;
                end else if (dly_cnt == 3'd0) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable_timer) begin
                    state_d = S_IDLE;
                end else if (at_shift && last_bit) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!enable_timer) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Configuration is frozen at start so mid-frame input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q   <= '0;
            size_q     <= '0;
            parity_q   <= 1'b0;
            two_stop_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            if (state_q == S_IDLE && enable_timer) begin
                if (cfg_ok) begin
                    period_q   <= bit_period;
                    size_q     <= data_size;
                    parity_q   <= parity_en;
                    two_stop_q <= two_stop;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dly_cnt <= '0;
        end else if (state_q == S_IDLE) begin
            dly_cnt <= 3'(DELAY_INIT);
        end else if (state_q == S_DELAY && dly_cnt != 3'd0) begin
            dly_cnt <= dly_cnt - 3'd1;
        end
    end

    // Counters run only while staying in RUN; any entry or exit restarts them.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_cnt <= '0;
        end else if (state_q != S_RUN || state_d != S_RUN) begin
            cnt     <= '0;
            bit_cnt <= '0;
        end else if (at_shift) begin
            cnt     <= PERIOD_W'(1);
            bit_cnt <= bit_cnt + (SIZE_W+1)'(1);
        end else begin
            cnt     <= cnt + PERIOD_W'(1);
        end
    end

    always_comb begin
        sample_strobe = 1'b0;
        shift_strobe  = 1'b0;
        packet_done   = 1'b0;
        bit_index     = '0;
        field         = FIELD_IDLE;
        busy          = (state_q == S_DELAY) || (state_q == S_RUN);
        cfg_error     = cfg_err_q;
        if (state_q == S_RUN) begin
            sample_strobe = at_sample;
            shift_strobe  = at_shift;
            packet_done   = at_shift && last_bit;
            bit_index     = bit_cnt;
            if ({1'b0, bit_cnt} < (SIZE_W+2)'(size_q)) begin
                field = FIELD_DATA;
            end else if (parity_q && ({1'b0, bit_cnt} == (SIZE_W+2)'(size_q))) begin
                field = FIELD_PARITY;
            end else begin
                field = FIELD_STOP;
            end
        end
    end

endmodule

// File: doc/rx_bit_timer.md
# rx_bit_timer

Parametrised bit timer for the UART receiver datapath. Once the receive controller arms it, it generates the per-bit timing for one serial frame. For every bit it produces a mid-bit sample strobe and an end-of-bit shift strobe, then flags packet completion. Compared with the fixed 8N1 timer, it adds configurable counter widths, an optional parity bit, 1 or 2 stop bits, abort on disarm, configuration checking and a re-arm interlock.

## Interface

- PERIOD_W, 14: width of the bit_period input and of the cycle counter.
- SIZE_W, 4: width of the data_size input; the bit index is SIZE_W+1 bits wide.
- START_DELAY, 2: cycles between arming and the first counted cycle, to align with the 2-flop synchroniser; legal range 0..7.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- enable_timer  input  1  level arm from the RX controller; a high-to-low transition mid-frame aborts the frame.
- bit_period  input  PERIOD_W  clocks per bit; must be ≥ 2.
- data_size  input  SIZE_W  data bits per frame; must be ≥ 1.
- parity_en  input  1  one parity bit follows the data bits.
- two_stop  input  1  0 selects 1 stop bit, 1 selects 2 stop bits.
- sample_strobe  output  1  one-cycle pulse at mid-bit.
- shift_strobe  output  1  one-cycle pulse at end of bit.
- packet_done  output  1  one-cycle pulse with the final shift_strobe of the frame.
- bit_index  output  SIZE_W+1  0-based index of the current bit.
- field  output  2  type of the current bit: 0 idle, 1 data, 2 parity, 3 stop.
- busy  output  1  high in DELAY and RUN.
- cfg_error  output  1  one-cycle pulse when a start is refused.

## Operation

- States: IDLE, DELAY, RUN, HOLD. Reset forces IDLE, clears all counters, and drives every output to 0.
- **IDLE:** when enable_timer is sampled high:
  - Configuration valid: latch bit_period, data_size, parity_en and two_stop, then go to DELAY, or straight to RUN if START_DELAY = 0.
  - Configuration invalid (bit_period < 2 or data_size == 0): pulse cfg_error for one cycle and go to HOLD.
- **Configuration latching:** input changes after the latch have no effect until the next start.
- **DELAY:** counts START_DELAY cycles, then enters RUN.
- **RUN, cycle counter:** cnt starts at 0 on RUN entry and increments every cycle.
  - sample_strobe is high while cnt == bit_period >> 1 (floor).
  - shift_strobe is high while cnt == bit_period; the next edge reloads cnt to 1, with no dead cycle between bits.
- **Frame length:** N = data_size + parity_en + (two_stop ? 2 : 1), computed at SIZE_W+2 bits wide so it cannot overflow.
- **Bit index and field:** bit_index increments on each shift_strobe edge.
  - field = data for index < data_size.
  - field = parity at index == data_size when parity_en is set.
  - field = stop for all remaining bits.
- **Frame end:** packet_done is asserted in the same cycle as the shift_strobe of bit N-1. The next edge goes to HOLD, zeroes cnt and bit_index, and sets field to 0.
- **HOLD:** waits for enable_timer to go low, then returns to IDLE. This stops a held arm from retriggering.
- **Abort:** enable_timer low while in DELAY or RUN takes effect on the next edge. The block goes to IDLE and clears the counters, with no packet_done. If a strobe condition coincides with the low sample, that strobe is still emitted that cycle.
- **Reset priority:** rst has priority over everything. Reset mid-frame gives IDLE on the next edge with no pulses.

## Timing

- Edge E0 samples the arm in IDLE. busy is high from E0 onward.
- The first sample_strobe occupies the cycle after edge E(START_DELAY + floor(P/2)). The first shift_strobe occupies the cycle after edge E(START_DELAY + P).
- Bit k's shift_strobe occupies the cycle after edge E(START_DELAY + (k+1)·P). packet_done coincides with k = N-1.
- busy falls at the edge after packet_done.
- Strobes are decoded from registered state only, with no combinational path from the inputs.
- Minimum period P = 2: sample and shift strobes fall on alternating cycles and never coincide.

## Test plan

- **8N1 frame:** P=10, data_size=8, parity off, 1 stop, START_DELAY=2, arm held.
  - Exactly 9 shift_strobes, at cycles 12, 22, …, 92 after E0; sample_strobes at 7, 17, ….
  - packet_done only at cycle 92; busy then drops and the block sits in HOLD with no retrigger until the arm is released.
- **7E2 frame:** P=4, data_size=7, parity on, 2 stop.
  - N=10; field sequence is 7×data, 1×parity, 2×stop; bit_index runs 0..9.
- **Minimum period:** P=2, data_size=1, parity off, 1 stop.
  - 2 bits; sample and shift strobes alternate every cycle; done at cycle 6 after E0.
- **Invalid configuration:**
  - P=1 with arm high: cfg_error pulses once, busy stays 0, no strobes.
  - data_size=0 with arm high: same response.
- **Abort:** drop enable_timer during bit 3 of an 8N1 frame.
  - Next edge gives IDLE with bit_index 0 and no packet_done.
  - Re-arming starts a fresh frame with correct timing.
- **Reset and mid-frame config change:**
  - rst asserted mid-frame: all outputs 0 on the next cycle.
  - Changing bit_period mid-frame does not alter current frame timing.
